// File: rtl/spi_slave.sv
// SPI slave with SCLK/SS/MOSI synchronized into clk_i, runtime-selectable
// CPOL/CPHA, back-to-back words while selected and a single-word tx buffer.
module spi_slave #(
    parameter int WordLength = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WordLength-1:0] din_i,
    input  logic                  load_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  sclk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [WordLength-1:0] dout_o,
    output logic                  spi_done_tick_o,
    output logic                  ready_o
);

    localparam int CntW = (WordLength > 2) ? $clog2(WordLength) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sclk_sync_q, ss_sync_q;
    logic [1:0]            mosi_sync_q;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d;
    logic                  skip_q, skip_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [WordLength-1:0] txbuf_q, txbuf_d;
    logic [WordLength-1:0] tx_q, tx_d;
    logic [WordLength-1:0] rx_q, rx_d;
    logic [WordLength-1:0] dout_q, dout_d;
    logic                  done_q, done_d;

    logic                  sclk_s, sclk_edge, lead_edge, trail_edge;
    logic                  sample_edge, shift_edge, ss_fall, ss_rise, mosi_s;
    logic [WordLength-1:0] next_word;

    // Bit 1 is the synchronized level; bit 2 is the previous level for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= {3{cpol_i}};
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
        end
    end

    assign sclk_s      = sclk_sync_q[1];
    assign sclk_edge   = sclk_sync_q[1] ^ sclk_sync_q[2];
    assign lead_edge   = sclk_edge & (sclk_s != cpol_q);
    assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
    assign mosi_s      = mosi_sync_q[1];
    assign next_word   = load_i ? din_i : txbuf_q;

    always_comb begin
        state_d = state_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        txbuf_d = next_word;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = XFER;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    skip_d  = cpha_i;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = next_word;
                end
            end
            XFER: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    skip_d  = 1'b0;
                    cnt_d   = '0;
                    rx_d    = '0;
                end else if (sample_edge) begin
                    rx_d = {rx_q[WordLength-2:0], mosi_s};
                    if (cnt_q == CntW'(WordLength - 1)) begin
                        cnt_d  = '0;
                        dout_d = {rx_q[WordLength-2:0], mosi_s};
                        done_d = 1'b1;
                        tx_d   = next_word;
                        skip_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (shift_edge) begin
                    // The first shift edge of a word only presents its MSB; refreshing
                    // from the buffer here lets a load just after the done tick still
                    // reach the word that is about to start.
                    if (skip_q) begin
                        tx_d   = next_word;
                        skip_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[WordLength-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
            txbuf_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            txbuf_q <= txbuf_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign miso_o          = (state_q == XFER) & tx_q[WordLength-1];
    assign miso_oe_o       = (state_q == XFER);
    assign ready_o         = (state_q == IDLE);
    assign dout_o          = dout_q;
    assign spi_done_tick_o = done_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: an SPI master model drives SCLK/SS/MOSI in all
// modes, captures MISO, and compares against hand-computed words.
module tb_spi_slave;

    localparam int HALF = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       load = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, done_tick, ready;
    logic [7:0] dout;

    int n_pass = 0;
    int n_total = 0;
    int tick_cnt = 0;
    int tick_base;
    logic [7:0] mi1, mi2;
    logic       seen;

    spi_slave #(.WordLength(8)) dut (
        .clk_i(clk), .rst_i(rst), .din_i(din), .load_i(load),
        .cpol_i(cpol), .cpha_i(cpha), .sclk_i(sclk), .ss_n_i(ss_n),
        .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe), .dout_o(dout),
        .spi_done_tick_o(done_tick), .ready_o(ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_tick) tick_cnt <= tick_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol; cpha = pha; sclk = pol;
        #(2*HALF);
    endtask

    task automatic select_slave();
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic deselect_slave();
        #HALF;
        ss_n = 1'b1;
        #(3*HALF);
    endtask

    task automatic load_word(input logic [7:0] w);
        @(negedge clk); din = w; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Master side: drives the top n bits of mo MSB-first, returns sampled MISO bits.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if (!cpha) begin
                mosi = mo[i]; #HALF;
                sclk = ~cpol; mi[i] = miso; #HALF;
                sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = mo[i]; #HALF;
                sclk = cpol; mi[i] = miso; #HALF;
            end
        end
    endtask

    task automatic wait_tick(output logic found);
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (done_tick) found = 1'b1;
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_tick", done_tick, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_ready", ready, 1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0: tx 0xA5, rx 0x3C
        set_mode(1'b0, 1'b0);
        load_word(8'hA5);
        tick_base = tick_cnt;
        select_slave();
        check("m0_oe_sel", miso_oe, 1'b1);
        check("m0_ready_sel", ready, 1'b0);
        spi_bits(8'h3C, 8, mi1);
        deselect_slave();
        check("m0_miso", mi1, 8'hA5);
        check("m0_dout", dout, 8'h3C);
        check("m0_ticks", tick_cnt - tick_base, 1);

        // Mode 3: tx 0x81, rx 0xF0
        set_mode(1'b1, 1'b1);
        load_word(8'h81);
        tick_base = tick_cnt;
        select_slave();
        spi_bits(8'hF0, 8, mi1);
        deselect_slave();
        check("m3_miso", mi1, 8'h81);
        check("m3_dout", dout, 8'hF0);
        check("m3_ticks", tick_cnt - tick_base, 1);

        // Mode 1: two words back-to-back, 0x55 loaded after the first tick
        set_mode(1'b0, 1'b1);
        load_word(8'hC3);
        tick_base = tick_cnt;
        select_slave();
        fork
            begin
                spi_bits(8'h12, 8, mi1);
                spi_bits(8'h34, 8, mi2);
            end
            begin
                wait_tick(seen);
                check("m1_tick1_seen", seen, 1'b1);
                check("m1_dout1", dout, 8'h12);
                din = 8'h55; load = 1'b1;
                @(negedge clk); load = 1'b0;
            end
        join
        deselect_slave();
        check("m1_miso1", mi1, 8'hC3);
        check("m1_miso2", mi2, 8'h55);
        check("m1_dout2", dout, 8'h34);
        check("m1_ticks", tick_cnt - tick_base, 2);

        // Abort after 5 bits: partial word discarded
        set_mode(1'b0, 1'b0);
        tick_base = tick_cnt;
        select_slave();
        spi_bits(8'hFF, 5, mi1);
        deselect_slave();
        check("abort_ticks", tick_cnt - tick_base, 0);
        check("abort_dout", dout, 8'h34);
        check("abort_ready", ready, 1'b1);
        check("abort_oe", miso_oe, 1'b0);

        // SCLK activity while deselected is ignored
        tick_base = tick_cnt;
        for (int k = 0; k < 16; k++) begin
            mosi = k[0]; sclk = ~sclk; #HALF;
        end
        sclk = cpol; #(2*HALF);
        check("idle_ticks", tick_cnt - tick_base, 0);
        check("idle_oe", miso_oe, 1'b0);
        check("idle_miso", miso, 1'b0);
        check("idle_ready", ready, 1'b1);

        // Reset at bit 3 of a transfer, then a clean transfer of 0x5A
        load_word(8'hE7);
        tick_base = tick_cnt;
        select_slave();
        spi_bits(8'h99, 3, mi1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mrst_dout", dout, 8'h00);
        check("mrst_tick", done_tick, 1'b0);
        check("mrst_miso", miso, 1'b0);
        check("mrst_oe", miso_oe, 1'b0);
        check("mrst_ready", ready, 1'b1);
        deselect_slave();
        check("mrst_ticks", tick_cnt - tick_base, 0);
        tick_base = tick_cnt;
        select_slave();
        spi_bits(8'h5A, 8, mi1);
        deselect_slave();
        check("post_rst_miso", mi1, 8'h00);
        check("post_rst_dout", dout, 8'h5A);
        check("post_rst_ticks", tick_cnt - tick_base, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
